pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_segment.sv | 41 ++++
 rtl/pipelined_adder.sv | 125 ++++++++++++
 tb/tb_pipelined_adder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and defaults for the pipelined adder/subtractor.
//   op_e         : operation select (OP_ADD = A+B, OP_SUB = A-B)
//   ADD_WIDTH    : default operand width
//   ADD_STAGES   : default pipeline depth
//   add_result_t : {sum, carry, ovf} bundle for result bookkeeping
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int ADD_WIDTH  = 32;
    localparam int ADD_STAGES = 4;

    typedef struct packed {
        logic [ADD_WIDTH-1:0] sum;
        logic                 carry;
        logic                 ovf;
    } add_result_t;

endpackage

// File: rtl/adder_segment.sv
// One carry segment of the pipelined adder: SEG-bit add with carry-in,
// result and carry-out registered, held while en_i is low.
//   clk, rst : clock, async active-high reset
//   en_i     : advance enable (low during a stall)
//   a_i, b_i : segment operands (b_i already inverted for subtract)
//   c_i      : carry into the segment
//   sum_o    : registered segment sum
//   carry_o  : registered carry out of the segment MSB
module adder_segment #(
    parameter int SEG = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic [SEG-1:0] sum_o,
    output logic           carry_o
);

    logic [SEG:0]   sum_d;
    logic [SEG-1:0] sum_q;
    logic           carry_q;

    assign sum_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, c_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (en_i) begin
            sum_q   <= sum_d[SEG-1:0];
            carry_q <= sum_d[SEG];
        end
    end

    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor. The carry chain is cut into STAGES segments of
// WIDTH/STAGES bits, one register stage per segment, with valid/ready flow
// control and full backpressure. Result appears STAGES registers after accept.
//   clk, rst                     : clock, async active-high reset
//   in_valid, in_ready           : input handshake
//   in_a, in_b, in_op            : operands and operation
//   out_valid, out_ready         : output handshake
//   out_sum, out_carry, out_ovf  : result, carry/no-borrow, signed overflow
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADD_WIDTH,
    parameter int STAGES = ADD_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  op_e              in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipelined_adder: STAGES must be in 1..WIDTH");
    end
    if (WIDTH % STAGES != 0) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    localparam int SEG = WIDTH / STAGES;

    logic              stall;
    logic              adv;
    logic [STAGES-1:0] vld_q;

    // Stage k inputs (_d) and the operand/partial-sum words registered
    // alongside segment k (_q). Only the bits above segment k of a_q/b_q and
    // the bits below it of lo_q carry information; the rest trims away.
    logic [WIDTH-1:0]  a_d  [STAGES];
    logic [WIDTH-1:0]  b_d  [STAGES];
    logic [WIDTH-1:0]  lo_d [STAGES];
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  lo_q [STAGES];
    logic [WIDTH-1:0]  word [STAGES];
    logic [STAGES-1:0] cin;
    logic [STAGES-1:0] seg_c;
    logic [WIDTH-1:0]  seg_sum;

    assign stall = vld_q[STAGES-1] && !out_ready;
    assign adv   = !stall;

    // Subtract as A + ~B + 1, folded in before the first segment.
    always_comb begin
        cin     = '0;
        a_d[0]  = in_a;
        b_d[0]  = (in_op == OP_SUB) ? ~in_b : in_b;
        lo_d[0] = '0;
        cin[0]  = (in_op == OP_SUB);
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]  = a_q[k-1];
            b_d[k]  = b_q[k-1];
            lo_d[k] = word[k-1];
            cin[k]  = seg_c[k-1];
        end
    end

    // Partial sum after stage k: earlier segments plus this stage's segment.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            word[k]                = lo_q[k];
            word[k][k*SEG +: SEG]  = seg_sum[k*SEG +: SEG];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_segment #(.SEG(SEG)) u_seg (
            .clk     (clk),
            .rst     (rst),
            .en_i    (adv),
            .a_i     (a_d[k][k*SEG +: SEG]),
            .b_i     (b_d[k][k*SEG +: SEG]),
            .c_i     (cin[k]),
            .sum_o   (seg_sum[k*SEG +: SEG]),
            .carry_o (seg_c[k])
        );
    end

    // Bubbles advance like real beats; everything freezes on a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                lo_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_d[k];
                b_q[k]  <= b_d[k];
                lo_q[k] <= lo_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign out_sum   = word[STAGES-1];
    assign out_carry = seg_c[STAGES-1];
    // Carry into the MSB is a^b'^sum at that bit; overflow is it XOR carry out.
    assign out_ovf   = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
                     ^ out_sum[WIDTH-1] ^ out_carry;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int ND = 3;
    int unsigned dw [ND] = '{32, 16, 64};
    int unsigned ds [ND] = '{4, 1, 8};

    typedef struct {
        logic [63:0] sum;
        logic        carry;
        logic        ovf;
    } res_t;

    typedef struct {
        op_e         op;
        logic [63:0] a;
        logic [63:0] b;
        add_result_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    op_e         in_op = OP_ADD;

    logic rdy0, vld0, c0, o0;
    logic rdy1, vld1, c1, o1;
    logic rdy2, vld2, c2, o2;
    logic [31:0] s0;
    logic [15:0] s1;
    logic [63:0] s2;

    int n_vec = 0;
    int n_bad = 0;

    res_t        sbq  [ND][$];
    logic        held [ND];
    logic [63:0] hs   [ND];
    logic        hc   [ND];
    logic        ho   [ND];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_op(in_op),
        .out_valid(vld0), .out_ready(out_ready),
        .out_sum(s0), .out_carry(c0), .out_ovf(o0));

    pipelined_adder #(.WIDTH(16), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_op(in_op),
        .out_valid(vld1), .out_ready(out_ready),
        .out_sum(s1), .out_carry(c1), .out_ovf(o1));

    pipelined_adder #(.WIDTH(64), .STAGES(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(vld2), .out_ready(out_ready),
        .out_sum(s2), .out_carry(c2), .out_ovf(o2));

    task automatic chk(input string name, input int d,
                       input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d (W=%0d,S=%0d): got %h expected %h",
                     name, d, dw[d], ds[d], act, exp);
        end
    endtask

    task automatic peek(input int d, output logic r, output logic v,
                        output logic [63:0] s, output logic c, output logic o);
        case (d)
            0:       begin r = rdy0; v = vld0; s = {32'b0, s0}; c = c0; o = o0; end
            1:       begin r = rdy1; v = vld1; s = {48'b0, s1}; c = c1; o = o1; end
            default: begin r = rdy2; v = vld2; s = s2;          c = c2; o = o2; end
        endcase
    endtask

    // Reference: unsigned compare for carry, sign rules for overflow.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input op_e op, input int w);
        logic [64:0] one;
        logic [63:0] m, aa, bb;
        logic [64:0] t;
        logic        sa, sb, sr;
        res_t        r;
        one = 65'd1;
        m   = 64'((one << w) - 65'd1);
        aa  = a & m;
        bb  = b & m;
        if (op == OP_ADD) begin
            t       = {1'b0, aa} + {1'b0, bb};
            r.carry = (t > {1'b0, m});
        end else begin
            t       = {1'b0, aa} - {1'b0, bb};
            r.carry = (aa >= bb);
        end
        r.sum = t[63:0] & m;
        sa = aa[w-1];
        sb = bb[w-1];
        sr = r.sum[w-1];
        r.ovf = (op == OP_ADD) ? (sa == sb && sr != sa) : (sa != sb && sr != sa);
        return r;
    endfunction

    // Scoreboard/monitor: looks at what will transfer on the coming edge.
    always @(negedge clk) begin
        logic r, v, c, o;
        logic [63:0] s;
        res_t e;
        if (rst) begin
            for (int d = 0; d < ND; d++) begin
                sbq[d].delete();
                held[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                peek(d, r, v, s, c, o);
                chk("in_ready_vs_stall", d, 64'(r), 64'(!(v && !out_ready)));
                if (held[d]) begin
                    chk("stall_valid_held", d, 64'(v), 64'd1);
                    chk("stall_sum_held", d, s, hs[d]);
                    chk("stall_flags_held", d, {62'b0, c, o}, {62'b0, hc[d], ho[d]});
                end
                held[d] = v && !out_ready;
                hs[d] = s;
                hc[d] = c;
                ho[d] = o;
                if (v && out_ready) begin
                    if (sbq[d].size() == 0) begin
                        chk("unexpected_beat", d, 64'd1, 64'd0);
                    end else begin
                        e = sbq[d].pop_front();
                        chk("sb_sum", d, s, e.sum);
                        chk("sb_carry", d, 64'(c), 64'(e.carry));
                        chk("sb_ovf", d, 64'(o), 64'(e.ovf));
                    end
                end
                if (in_valid && r)
                    sbq[d].push_back(model(in_a, in_b, in_op, dw[d]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat, then measure latency in edges (accept edge counts as 1).
    task automatic apply_vec(input vec_t v);
        int   lat [ND];
        logic seen [ND];
        logic r, vv, c, o;
        logic [63:0] s;
        for (int d = 0; d < ND; d++) begin
            lat[d]  = 0;
            seen[d] = 1'b0;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_op     = v.op;
        chk("ready_before_accept", 0, 64'(rdy0), 64'd1);
        step();
        in_valid = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            for (int d = 0; d < ND; d++) begin
                peek(d, r, vv, s, c, o);
                if (!seen[d] && vv) begin
                    seen[d] = 1'b1;
                    lat[d]  = e;
                    if (d == 0) begin
                        chk("vec_sum", 0, s, {32'b0, v.exp.sum});
                        chk("vec_carry", 0, 64'(c), 64'(v.exp.carry));
                        chk("vec_ovf", 0, 64'(o), 64'(v.exp.ovf));
                    end
                end
            end
            step();
        end
        for (int d = 0; d < ND; d++)
            chk("latency", d, 64'(lat[d]), 64'(ds[d]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        logic r, v, c, o;
        logic [63:0] s;
        logic [3:0] pat;
        pat = 4'b1001;

        tbl[0] = '{OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '{32'h0000_0000, 1'b1, 1'b0}};
        tbl[1] = '{OP_ADD, 64'h7FFF_FFFF, 64'd1,           '{32'h8000_0000, 1'b0, 1'b1}};
        tbl[2] = '{OP_SUB, 64'h8000_0000, 64'd1,           '{32'h7FFF_FFFF, 1'b1, 1'b1}};
        tbl[3] = '{OP_SUB, 64'd5, 64'd7,                   '{32'hFFFF_FFFE, 1'b0, 1'b0}};
        tbl[4] = '{OP_SUB, 64'd7, 64'd5,                   '{32'h0000_0002, 1'b1, 1'b0}};
        tbl[5] = '{OP_ADD, 64'd10, 64'd20,                 '{32'd30,        1'b0, 1'b0}};
        tbl[6] = '{OP_ADD, 64'h8000_0000, 64'h8000_0000,   '{32'h0000_0000, 1'b1, 1'b1}};
        tbl[7] = '{OP_SUB, 64'd0, 64'd0,                   '{32'h0000_0000, 1'b1, 1'b0}};
        tbl[8] = '{OP_ADD, 64'h0000_FFFF, 64'd1,           '{32'h0001_0000, 1'b0, 1'b0}};
        tbl[9] = '{OP_SUB, 64'd0, 64'h8000_0000,           '{32'h8000_0000, 1'b0, 1'b1}};

        // Reset state
        step();
        for (int d = 0; d < ND; d++) begin
            peek(d, r, v, s, c, o);
            chk("reset_valid", d, 64'(v), 64'd0);
            chk("reset_sum", d, s, 64'd0);
            chk("reset_flags", d, {62'b0, c, o}, 64'd0);
        end
        step();
        rst = 1'b0;
        step();
        for (int d = 0; d < ND; d++) begin
            peek(d, r, v, s, c, o);
            chk("ready_after_reset", d, 64'(r), 64'd1);
        end

        // Directed vectors
        for (int i = 0; i < 10; i++)
            apply_vec(tbl[i]);

        // Random streaming with out_ready 1,0,0,1,...
        for (int cyc = 0; cyc < 64; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = {$urandom, $urandom};
            in_b      = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) in_a = '1;
            if ($urandom_range(0, 5) == 0) in_b = 64'h8000_0000_8000_8000;
            in_op     = op_e'($urandom_range(0, 1));
            out_ready = pat[cyc % 4];
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (16) step();
        for (int d = 0; d < ND; d++)
            chk("drain_empty", d, 64'(sbq[d].size()), 64'd0);

        // Reset with beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 64'(100 + i);
            in_b     = 64'(i);
            in_op    = OP_ADD;
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            peek(d, r, v, s, c, o);
            chk("midrst_valid", d, 64'(v), 64'd0);
            chk("midrst_sum", d, s, 64'd0);
            chk("midrst_flags", d, {62'b0, c, o}, 64'd0);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            for (int d = 0; d < ND; d++) begin
                peek(d, r, v, s, c, o);
                chk("no_stale_beat", d, 64'(v), 64'd0);
            end
        end
        apply_vec(tbl[5]);
        repeat (4) step();
        for (int d = 0; d < ND; d++)
            chk("final_empty", d, 64'(sbq[d].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
